fm_spy_buffer_ch: RTL

- Parametrised single-channel spy/playback buffer for the FM (fast monitoring) subsystem, successor to the fixed-width spy buffer channels.
- Captures an arbitrary-width tapped bus into a circular RAM whose word width is auto-rounded to 32/64/128/256.
- Supports freeze-on-trigger with a programmable post-trigger window, and one-shot or looped playback.
- Exposes a 32-bit sliced register-side read/write port for the AXI register map.

---
 rtl/fm_spy_buffer_ch_if.sv | 37 +++
 rtl/fm_spy_buffer_ch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_spy_buffer_ch_if.sv
`default_nettype none
//==============================================================================
// Module      : fm_spy_buffer_ch_if
// Description : Register-side access bundle for one FM spy buffer channel.
//               Carries the 32-bit sliced read/write port used by the AXI
//               register map.
//                 cfg_addr   [ADDR_W-1:0]       = RAM entry
//                            [ADDR_W+2:ADDR_W]  = 32-bit slice index
//                 cfg_wr_en  / cfg_wdata        = slice write strobe / data
//                 cfg_rd_en                     = slice read strobe
//                 cfg_rdata  / cfg_rd_vld       = read data / valid (1 cycle later)
//                 cfg_err                       = pulse on rejected access
//               master: register map side, slave: spy buffer side.
// Revision    : 1.0 - initial release
//==============================================================================
interface fm_spy_buffer_ch_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W+2:0] cfg_addr;
    logic              cfg_wr_en;
    logic [31:0]       cfg_wdata;
    logic              cfg_rd_en;
    logic [31:0]       cfg_rdata;
    logic              cfg_rd_vld;
    logic              cfg_err;

    modport master (
        output cfg_addr, cfg_wr_en, cfg_wdata, cfg_rd_en,
        input  cfg_rdata, cfg_rd_vld, cfg_err
    );

    modport slave (
        input  cfg_addr, cfg_wr_en, cfg_wdata, cfg_rd_en,
        output cfg_rdata, cfg_rd_vld, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/fm_spy_buffer_ch.sv
`default_nettype none
//==============================================================================
// Module      : fm_spy_buffer_ch
// Description : Single-channel spy/playback buffer for fast monitoring.
//               Captures a TP_DW-wide tapped bus into a circular RAM whose
//               word width is rounded up to 32/64/128/256 bits. Supports
//               freeze-on-trigger with a post-trigger window and one-shot
//               or looped playback, plus a 32-bit sliced register port.
// Ports       : spy_clock / spy_rst_n   clock, async active-low reset
//               tap_data / tap_vld      monitored bus and qualifier
//               pb_mode                 0=SPY 1=TRIG 2=PB_ONCE 3=PB_LOOP
//               arm / freeze_req        start pulse / trigger-stop pulse
//               post_trig_len           TRIG: post-trigger writes,
//                                       PB: last playback address
//               cfg (slave modport)     sliced register access
//               pb_data / pb_vld / pb_done  playback stream
//               frozen / wrapped / wr_ptr / trig_ptr  capture status
// Revision    : 1.0 - initial release
//==============================================================================
module fm_spy_buffer_ch #(
    parameter int TP_DW  = 51,
    parameter int AXI_DW = 32,
    parameter int ADDR_W = 10
) (
    input  wire                 spy_clock,
    input  wire                 spy_rst_n,
    input  wire  [TP_DW-1:0]    tap_data,
    input  wire                 tap_vld,
    input  wire  [1:0]          pb_mode,
    input  wire                 arm,
    input  wire                 freeze_req,
    input  wire  [ADDR_W-1:0]   post_trig_len,
    fm_spy_buffer_ch_if.slave   cfg,
    output logic [TP_DW-1:0]    pb_data,
    output logic                pb_vld,
    output logic                pb_done,
    output logic                frozen,
    output logic                wrapped,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [ADDR_W-1:0]   trig_ptr
);

    //--------------------------------------------------------------------------
    // Derived constants
    //--------------------------------------------------------------------------
    localparam int c_SB_DW  = (TP_DW <= 32)  ? 32  :
                              (TP_DW <= 64)  ? 64  :
                              (TP_DW <= 128) ? 128 : 256;
    localparam int c_NSLICE = c_SB_DW / 32;
    localparam int c_DEPTH  = 1 << ADDR_W;

    localparam logic [3:0]          c_NSLICE_W = 4'(c_NSLICE);
    localparam logic [ADDR_W-1:0]   c_PTR_MAX  = {ADDR_W{1'b1}};
    // Bits at or above TP_DW are never stored as ones.
    localparam logic [c_SB_DW-1:0]  c_TP_MASK  = {c_SB_DW{1'b1}} >> (c_SB_DW - TP_DW);

    localparam logic [1:0] c_MODE_SPY  = 2'd0;
    localparam logic [1:0] c_MODE_TRIG = 2'd1;
    localparam logic [1:0] c_MODE_ONCE = 2'd2;
    localparam logic [1:0] c_MODE_LOOP = 2'd3;

    generate
        if (TP_DW < 1 || TP_DW > 256) begin : g_bad_tp_dw
            $error("fm_spy_buffer_ch: TP_DW must be in 1..256");
        end
        if (AXI_DW != 32) begin : g_bad_axi_dw
            $error("fm_spy_buffer_ch: AXI_DW must be 32");
        end
    endgenerate

    //--------------------------------------------------------------------------
    // State machine
    //--------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAPTURE   = 3'd1,
        S_POST_TRIG = 3'd2,
        S_FROZEN    = 3'd3,
        S_PLAYBACK  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_wrapped;
    logic [ADDR_W-1:0]   r_trig_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic                r_pb_vld;
    logic                r_pb_done;
    logic [TP_DW-1:0]    r_pb_data;
    logic [31:0]         r_cfg_rdata;
    logic                r_cfg_rd_vld;
    logic                r_cfg_err;

    logic                w_tap_we;
    logic                w_pb_re;
    logic                w_pb_last;
    logic                w_trig;
    logic                w_enter_pt;

    // Storage, no reset: contents survive spy_rst_n.
    logic [c_SB_DW-1:0]  r_mem [c_DEPTH];

    //--------------------------------------------------------------------------
    // Register-side decode
    //--------------------------------------------------------------------------
    logic [ADDR_W-1:0]   w_cfg_entry;
    logic [2:0]          w_cfg_slice;
    logic                w_cfg_open;
    logic                w_cfg_slice_ok;
    logic                w_cfg_wr;
    logic                w_cfg_rd;
    logic                w_cfg_err;
    logic [c_SB_DW-1:0]  w_cfg_word;
    logic [31:0]         w_cfg_rd_slice;
    logic [c_SB_DW-1:0]  w_pb_word;

    assign w_cfg_entry    = cfg.cfg_addr[ADDR_W-1:0];
    assign w_cfg_slice    = cfg.cfg_addr[ADDR_W+2:ADDR_W];
    assign w_cfg_open     = (r_state == S_IDLE) || (r_state == S_FROZEN);
    assign w_cfg_slice_ok = ({1'b0, w_cfg_slice} < c_NSLICE_W);
    // Writes to slices beyond the RAM word are silently dropped.
    assign w_cfg_wr       = w_cfg_open && cfg.cfg_wr_en && w_cfg_slice_ok;
    // A read colliding with a write loses; the write still goes ahead.
    assign w_cfg_rd       = w_cfg_open && cfg.cfg_rd_en && !cfg.cfg_wr_en;
    assign w_cfg_err      = ((cfg.cfg_wr_en || cfg.cfg_rd_en) && !w_cfg_open) ||
                            (cfg.cfg_wr_en && cfg.cfg_rd_en);

    assign w_cfg_word     = r_mem[w_cfg_entry];
    assign w_pb_word      = r_mem[r_rd_ptr];

    always_comb begin
        w_cfg_rd_slice = '0;
        for (int s = 0; s < c_NSLICE; s++) begin
            if (w_cfg_slice == 3'(s)) begin
                w_cfg_rd_slice = w_cfg_word[s*32 +: 32];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tap_we    = 1'b0;
        w_pb_re     = 1'b0;
        w_pb_last   = 1'b0;
        w_trig      = 1'b0;
        w_enter_pt  = 1'b0;

        if (arm) begin
            // arm restarts from any state; nothing else happens this cycle,
            // so an in-flight playback read is simply never issued.
            w_state_nxt = pb_mode[1] ? S_PLAYBACK : S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    w_tap_we = tap_vld;
                    if (freeze_req) begin
                        w_trig = 1'b1;
                        if ((r_mode == c_MODE_TRIG) && (post_trig_len != '0)) begin
                            w_state_nxt = S_POST_TRIG;
                            w_enter_pt  = 1'b1;
                        end else begin
                            w_state_nxt = S_FROZEN;
                        end
                    end
                end
                S_POST_TRIG: begin
                    w_tap_we = tap_vld;
                    if (tap_vld && (r_cnt == ADDR_W'(1))) begin
                        w_state_nxt = S_FROZEN;
                    end
                end
                S_PLAYBACK: begin
                    w_pb_re   = 1'b1;
                    w_pb_last = (r_rd_ptr == post_trig_len);
                    if (r_mode == c_MODE_LOOP) begin
                        if (freeze_req) begin
                            w_state_nxt = S_FROZEN;
                        end
                    end else if (w_pb_last) begin
                        w_state_nxt = S_FROZEN;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Sequential state and datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge spy_clock or negedge spy_rst_n) begin
        if (!spy_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge spy_clock or negedge spy_rst_n) begin
        if (!spy_rst_n) begin
            r_mode       <= c_MODE_SPY;
            r_wr_ptr     <= '0;
            r_wrapped    <= 1'b0;
            r_trig_ptr   <= '0;
            r_cnt        <= '0;
            r_rd_ptr     <= '0;
            r_pb_vld     <= 1'b0;
            r_pb_done    <= 1'b0;
            r_pb_data    <= '0;
            r_cfg_rdata  <= '0;
            r_cfg_rd_vld <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (arm) begin
                r_mode <= pb_mode;
                if (!pb_mode[1]) begin
                    r_wr_ptr  <= '0;
                    r_wrapped <= 1'b0;
                end else begin
                    r_rd_ptr  <= '0;
                end
            end

            if (w_tap_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_wr_ptr == c_PTR_MAX) begin
                    r_wrapped <= 1'b1;
                end
            end

            // Trigger pointer reflects a same-cycle tap write.
            if (w_trig) begin
                r_trig_ptr <= w_tap_we ? (r_wr_ptr + 1'b1) : r_wr_ptr;
            end

            if (w_enter_pt) begin
                r_cnt <= post_trig_len;
            end else if ((r_state == S_POST_TRIG) && w_tap_we) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_pb_re) begin
                r_rd_ptr <= w_pb_last ? '0 : (r_rd_ptr + 1'b1);
            end

            r_pb_vld  <= w_pb_re;
            r_pb_done <= w_pb_re && w_pb_last && (r_mode == c_MODE_ONCE);
            r_pb_data <= w_pb_re ? w_pb_word[TP_DW-1:0] : '0;

            r_cfg_err    <= w_cfg_err;
            r_cfg_rd_vld <= w_cfg_rd;
            if (w_cfg_rd) begin
                r_cfg_rdata <= w_cfg_rd_slice;
            end
        end
    end

    //--------------------------------------------------------------------------
    // RAM write port with per-slice enables. Tap writes fill the whole word
    // (zero-extended); register writes touch a single 32-bit slice.
    //--------------------------------------------------------------------------
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [c_SB_DW-1:0]  w_mem_wdata;
    logic [c_NSLICE-1:0] w_slice_we;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_wr_ptr;
        w_mem_wdata = '0;
        w_slice_we  = '0;
        if (w_tap_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_wr_ptr;
            w_mem_wdata = c_SB_DW'(tap_data);
            w_slice_we  = '1;
        end else if (w_cfg_wr) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_cfg_entry;
            w_mem_wdata = {c_NSLICE{cfg.cfg_wdata}} & c_TP_MASK;
            for (int s = 0; s < c_NSLICE; s++) begin
                w_slice_we[s] = (w_cfg_slice == 3'(s));
            end
        end
    end

    always_ff @(posedge spy_clock) begin
        if (w_mem_we) begin
            for (int s = 0; s < c_NSLICE; s++) begin
                if (w_slice_we[s]) begin
                    r_mem[w_mem_addr][s*32 +: 32] <= w_mem_wdata[s*32 +: 32];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign pb_data        = r_pb_data;
    assign pb_vld         = r_pb_vld;
    assign pb_done        = r_pb_done;
    assign frozen         = (r_state == S_FROZEN);
    assign wrapped        = r_wrapped;
    assign wr_ptr         = r_wr_ptr;
    assign trig_ptr       = r_trig_ptr;
    assign cfg.cfg_rdata  = r_cfg_rdata;
    assign cfg.cfg_rd_vld = r_cfg_rd_vld;
    assign cfg.cfg_err    = r_cfg_err;

endmodule
`default_nettype wire
